// File: rtl/game_sequencer.sv
// game_sequencer: game controller for the 4x4 flip-cell puzzle.
// Scrambles the board, forwards user moves, counts moves, latches win.
module game_sequencer #(
    parameter int         SCRAMBLE_MOVES = 8,
    parameter logic [7:0] LFSR_SEED      = 8'hA5,
    parameter int         SETTLE         = 4,
    parameter int         MOVE_W         = 8,
    parameter int         BUZZ_CYCLES    = 100000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              user_fire,
    input  logic [3:0]        user_row,
    input  logic [3:0]        user_col,
    input  logic              user_error,
    input  logic              win_in,
    output logic [3:0]        row_en,
    output logic [3:0]        col_en,
    output logic              fire_out,
    output logic              busy,
    output logic [1:0]        game_state,
    output logic [MOVE_W-1:0] move_count,
    output logic              buzz_en
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int BW = $clog2(BUZZ_CYCLES + 1);

    localparam logic [7:0]    L_SCR = 8'(SCRAMBLE_MOVES);
    localparam logic [SW-1:0] L_SET = SW'(SETTLE - 1);
    localparam logic [BW-1:0] L_BZ  = BW'(BUZZ_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCR  = 2'd1,
        S_PLAY = 2'd2,
        S_WIN  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        P_IDLE,
        P_EN,
        P_FIRE,
        P_SETTLE
    } phase_t;

    state_t            r_state;
    phase_t            r_phase;
    logic [SW-1:0]     r_set_cnt;
    logic [3:0]        r_row;
    logic [3:0]        r_col;
    logic [7:0]        r_lfsr;
    logic [7:0]        r_scnt;
    logic [MOVE_W-1:0] r_mcnt;
    logic              r_buzz;
    logic [BW-1:0]     r_bcnt;
    logic              r_chk;
    logic              r_spend;

    state_t            w_state;
    phase_t            w_phase;
    logic [SW-1:0]     w_set_cnt;
    logic [3:0]        w_row;
    logic [3:0]        w_col;
    logic [7:0]        w_lfsr;
    logic [7:0]        w_scnt;
    logic [MOVE_W-1:0] w_mcnt;
    logic              w_buzz;
    logic [BW-1:0]     w_bcnt;
    logic              w_chk;
    logic              w_spend;
    logic              w_launch;

    logic              w_idle;
    logic [3:0]        w_oh;
    logic              w_fb;
    logic              w_row_oh;
    logic              w_col_oh;
    logic              w_user_ok;
    logic              w_scr_more;

    assign w_idle = (r_phase == P_IDLE);
    assign w_oh   = 4'b0001 << r_lfsr[1:0];
    assign w_fb   = r_lfsr[7] ^ r_lfsr[5]
                  ^ r_lfsr[4] ^ r_lfsr[3];

    assign w_row_oh = (user_row != 4'b0000) &&
                      ((user_row & (user_row - 4'd1)) == 4'b0000);
    assign w_col_oh = (user_col != 4'b0000) &&
                      ((user_col & (user_col - 4'd1)) == 4'b0000);

    assign w_user_ok = !user_error &&
                       ((w_row_oh && (user_col == 4'b0000)) ||
                        (w_col_oh && (user_row == 4'b0000)));

    assign w_scr_more = (r_scnt != L_SCR);

    // Fire sequencer: enables, strobe, then settle countdown.
    always_comb begin
        w_phase   = r_phase;
        w_set_cnt = r_set_cnt;
        unique case (r_phase)
            P_IDLE: begin
                if (w_launch) begin
                    w_phase = P_EN;
                end
            end
            P_EN: begin
                w_phase = P_FIRE;
            end
            P_FIRE: begin
                if (SETTLE == 0) begin
                    w_phase = P_IDLE;
                end else begin
                    w_phase   = P_SETTLE;
                    w_set_cnt = L_SET;
                end
            end
            P_SETTLE: begin
                if (r_set_cnt == '0) begin
                    w_phase = P_IDLE;
                end else begin
                    w_set_cnt = r_set_cnt - 1'b1;
                end
            end
        endcase
    end

    // Game FSM: decides launches, counters and state changes.
    always_comb begin
        w_state  = r_state;
        w_row    = r_row;
        w_col    = r_col;
        w_lfsr   = r_lfsr;
        w_scnt   = r_scnt;
        w_mcnt   = r_mcnt;
        w_buzz   = r_buzz;
        w_bcnt   = r_bcnt;
        w_chk    = r_chk;
        w_spend  = r_spend;
        w_launch = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state = S_SCR;
                    w_mcnt  = '0;
                    w_scnt  = '0;
                end
            end
            S_SCR: begin
                if (start) begin
                    w_scnt = '0;
                    w_mcnt = '0;
                end else if (w_idle) begin
                    if (w_scr_more || win_in) begin
                        w_launch = 1'b1;
                        w_row    = r_lfsr[2] ? 4'b0000 : w_oh;
                        w_col    = r_lfsr[2] ? w_oh : 4'b0000;
                        w_lfsr   = {r_lfsr[6:0], w_fb};
                        if (w_scr_more) begin
                            w_scnt = r_scnt + 8'd1;
                        end
                    end else begin
                        w_state = S_PLAY;
                    end
                end
            end
            S_PLAY: begin
                if (w_idle) begin
                    w_chk = 1'b0;
                    if (start || r_spend) begin
                        w_state = S_SCR;
                        w_mcnt  = '0;
                        w_scnt  = '0;
                        w_spend = 1'b0;
                    end else if (r_chk && win_in) begin
                        w_state = S_WIN;
                        w_buzz  = 1'b1;
                        w_bcnt  = '0;
                    end else if (user_fire && w_user_ok) begin
                        w_launch = 1'b1;
                        w_row    = user_row;
                        w_col    = user_col;
                        w_chk    = 1'b1;
                        if (!(&r_mcnt)) begin
                            w_mcnt = r_mcnt + 1'b1;
                        end
                    end
                end else if (start) begin
                    w_spend = 1'b1;
                end
            end
            S_WIN: begin
                if (start) begin
                    w_state = S_SCR;
                    w_mcnt  = '0;
                    w_scnt  = '0;
                    w_buzz  = 1'b0;
                end else if (r_buzz) begin
                    if (r_bcnt == L_BZ) begin
                        w_buzz = 1'b0;
                    end else begin
                        w_bcnt = r_bcnt + 1'b1;
                    end
                end
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_phase   <= P_IDLE;
            r_set_cnt <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_lfsr    <= LFSR_SEED;
            r_scnt    <= '0;
            r_mcnt    <= '0;
            r_buzz    <= 1'b0;
            r_bcnt    <= '0;
            r_chk     <= 1'b0;
            r_spend   <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_phase   <= w_phase;
            r_set_cnt <= w_set_cnt;
            r_row     <= w_row;
            r_col     <= w_col;
            r_lfsr    <= w_lfsr;
            r_scnt    <= w_scnt;
            r_mcnt    <= w_mcnt;
            r_buzz    <= w_buzz;
            r_bcnt    <= w_bcnt;
            r_chk     <= w_chk;
            r_spend   <= w_spend;
        end
    end

    logic w_drive;
    assign w_drive = (r_phase == P_EN) || (r_phase == P_FIRE);

    assign row_en     = w_drive ? r_row : 4'b0000;
    assign col_en     = w_drive ? r_col : 4'b0000;
    assign fire_out   = (r_phase == P_FIRE);
    assign busy       = !w_idle;
    assign game_state = r_state;
    assign move_count = r_mcnt;
    assign buzz_en    = r_buzz;

endmodule
